// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared PDM constants, audio sample type and saturation helpers
package pdm_pkg;

  localparam int PDM_COUNT_PERIOD = 32;
  localparam int NUM_PDM_SAMPLES  = 256;

  typedef logic signed [7:0] audio_sample_t;

  function automatic logic signed [11:0] sat12(input logic signed [12:0] v);
    if (v > 13'sd2047) return 12'h7FF;
    if (v < -13'sd2048) return 12'h800;
    return v[11:0];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767) return 16'h7FFF;
    if (v < -17'sd32768) return 16'h8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/pdm_sample_fifo.sv
// rtl/pdm_sample_fifo.sv - synchronous sample FIFO with level; push/pop are ignored when full/empty
module pdm_sample_fifo
  import pdm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/pdm_audio_tx.sv
// rtl/pdm_audio_tx.sv - PDM playback transmitter: sample FIFO, bit timing and modulator
// Define PDM_SECOND_ORDER_EN to use the second-order modulator instead of the first-order accumulator.
module pdm_audio_tx #(
  parameter int PDM_COUNT_PERIOD = pdm_pkg::PDM_COUNT_PERIOD,
  parameter int NUM_PDM_SAMPLES  = pdm_pkg::NUM_PDM_SAMPLES,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           enable_in,
  input  pdm_pkg::audio_sample_t         audio_in,
  input  logic                           audio_valid_in,
  output logic                           audio_ready_out,
  output logic                           pdm_clk_out,
  output logic                           pdm_out,
  output logic                           underrun_out,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_out
);
  import pdm_pkg::*;

  localparam int CW = $clog2(PDM_COUNT_PERIOD);
  localparam int SW = $clog2(NUM_PDM_SAMPLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(PDM_COUNT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(PDM_COUNT_PERIOD / 2);
  localparam logic [SW-1:0] SMP_MAX  = SW'(NUM_PDM_SAMPLES - 1);

  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_nxt;
  logic [SW-1:0]  r_samp;
  audio_sample_t  r_sample;
  audio_sample_t  w_fifo_data;
  logic           w_full;
  logic           w_empty;
  logic           w_bit_step;
  logic           w_wrap;
  logic           w_mod_bit;
  logic           r_pdm_clk;
  logic           r_pdm_out;
  logic           r_underrun;

  assign w_bit_step  = enable_in && (r_count == CNT_MAX);
  assign w_wrap      = w_bit_step && (r_samp == SMP_MAX);
  assign w_count_nxt = (r_count == CNT_MAX) ? '0 : r_count + CW'(1);

  assign audio_ready_out = !w_full;
  assign pdm_clk_out     = r_pdm_clk;
  assign pdm_out         = r_pdm_out;
  assign underrun_out    = r_underrun;

  pdm_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_push  (audio_valid_in),
    .i_wdata (audio_in),
    .i_pop   (w_wrap),
    .o_rdata (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level_out)
  );

  // pdm_clk rises on the same edge that updates pdm_out, so data is stable at the falling edge
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_count    <= '0;
      r_samp     <= '0;
      r_sample   <= '0;
      r_pdm_clk  <= 1'b0;
      r_pdm_out  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_wrap && w_empty;
      if (enable_in) begin
        r_count   <= w_count_nxt;
        r_pdm_clk <= (w_count_nxt < CNT_HALF);
        if (w_bit_step) begin
          r_samp    <= (r_samp == SMP_MAX) ? '0 : r_samp + SW'(1);
          r_pdm_out <= w_mod_bit;
          if (w_wrap && !w_empty) r_sample <= w_fifo_data;
        end
      end else begin
        r_pdm_clk <= 1'b0;
        r_pdm_out <= 1'b0;
      end
    end
  end

`ifdef PDM_SECOND_ORDER_EN
  logic signed [11:0] r_i1;
  logic signed [11:0] w_i1;
  logic signed [15:0] r_i2;
  logic signed [15:0] w_i2;
  logic signed [12:0] w_fb;
  logic               r_mod_bit;

  assign w_fb      = r_mod_bit ? 13'sd128 : -13'sd128;
  assign w_i1      = sat12(13'(r_i1) + 13'(r_sample) - w_fb);
  assign w_i2      = sat16(17'(r_i2) + 17'(w_i1) - 17'(w_fb));
  assign w_mod_bit = !w_i2[15];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_i1      <= '0;
      r_i2      <= '0;
      r_mod_bit <= 1'b0;
    end else if (w_bit_step) begin
      r_i1      <= w_i1;
      r_i2      <= w_i2;
      r_mod_bit <= w_mod_bit;
    end
  end
`else
  logic [7:0] r_acc;
  logic [8:0] w_sum;

  // offset binary u = sample + 128 is the sample with its sign bit inverted
  assign w_sum     = {1'b0, r_acc} + {1'b0, ~r_sample[7], r_sample[6:0]};
  assign w_mod_bit = w_sum[8];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_acc <= '0;
    end else if (w_bit_step) begin
      r_acc <= w_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_pdm_audio_tx.sv
// tb/tb_pdm_audio_tx.sv - directed bench for pdm_audio_tx: reset, FIFO full, async reset, playback table, underrun
module tb_pdm_audio_tx;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       enable_in = 1'b0;
  logic [7:0] audio_in = 8'h00;
  logic       audio_valid_in = 1'b0;
  logic       audio_ready_out;
  logic       pdm_clk_out;
  logic       pdm_out;
  logic       underrun_out;
  logic [4:0] fifo_level_out;

  int n_cmp = 0;
  int n_bad = 0;
  int n_under = 0;

  pdm_audio_tx #(
    .PDM_COUNT_PERIOD (32),
    .NUM_PDM_SAMPLES  (256),
    .FIFO_DEPTH       (16)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .audio_in        (audio_in),
    .audio_valid_in  (audio_valid_in),
    .audio_ready_out (audio_ready_out),
    .pdm_clk_out     (pdm_clk_out),
    .pdm_out         (pdm_out),
    .underrun_out    (underrun_out),
    .fifo_level_out  (fifo_level_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (underrun_out === 1'b1) n_under++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] smp;
    bit         pre;
    int         ones;
    logic [7:0] pat;
    logic       ur;
    int         lvl;
  } vec_t;

  vec_t tv[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [7:0] v, output logic rdy_pre);
    audio_in = v;
    audio_valid_in = 1'b1;
    rdy_pre = audio_ready_out;
    tick(1);
    audio_valid_in = 1'b0;
  endtask

  // Plays one full 256-bit sample period; starts just after a wrap edge (or after enabling from reset).
  task automatic run_period(input string tag, input int pause_at, input bit push_end,
                            input logic [7:0] push_val, output int ones,
                            output logic [7:0] pat, output logic ur_end);
    int clk_err;
    ones = 0;
    pat = 8'h00;
    clk_err = 0;
    for (int k = 0; k < 256; k++) begin
      if (k == pause_at) begin
        enable_in = 1'b0;
        tick(50);
        check({tag, "_pause_clk"}, pdm_clk_out, 0);
        check({tag, "_pause_out"}, pdm_out, 0);
        enable_in = 1'b1;
      end
      tick(15);
      if (pdm_clk_out !== 1'b1) clk_err++;
      tick(1);
      if (pdm_clk_out !== 1'b0) clk_err++;
      tick(15);
      if (push_end && k == 255) begin
        audio_in = push_val;
        audio_valid_in = 1'b1;
      end
      tick(1);
      audio_valid_in = 1'b0;
      if (pdm_clk_out !== 1'b1) clk_err++;
      ones += int'(pdm_out);
      if (k < 8) pat = {pat[6:0], pdm_out};
    end
    ur_end = underrun_out;
    check({tag, "_clk_shape"}, clk_err, 0);
  endtask

  task automatic check_period(input string tag, input int ones, input logic [7:0] pat,
                              input int exp_ones, input logic [7:0] exp_pat);
`ifdef PDM_SECOND_ORDER_EN
    check({tag, "_ones_near"}, (ones >= exp_ones - 2) && (ones <= exp_ones + 2), 1);
`else
    check({tag, "_ones"}, ones, exp_ones);
    check({tag, "_pat"}, pat, exp_pat);
`endif
  endtask

  initial begin
    logic       rdy;
    int         ones;
    logic [7:0] pat;
    logic       ur;

    tv[0] = '{8'h00, 1'b0, 128, 8'h55, 1'b0, 3};
    tv[1] = '{8'h80, 1'b1,   0, 8'h00, 1'b0, 2};
    tv[2] = '{8'h7F, 1'b1, 255, 8'h7F, 1'b0, 1};
    tv[3] = '{8'h40, 1'b1, 192, 8'h77, 1'b0, 0};
    tv[4] = '{8'hC0, 1'b1,  64, 8'h11, 1'b1, 0};

    tick(3);
    check("rst_ready", audio_ready_out, 1);
    check("rst_pdm_clk", pdm_clk_out, 0);
    check("rst_pdm_out", pdm_out, 0);
    check("rst_underrun", underrun_out, 0);
    check("rst_level", fifo_level_out, 0);
    rst_in = 1'b1;

    for (int i = 0; i < 17; i++) begin
      push(8'(i * 5), rdy);
      if (i == 0)  check("fill_level1", fifo_level_out, 1);
      if (i == 14) check("fill_ready15", audio_ready_out, 1);
      if (i == 15) begin
        check("fill_ready16", audio_ready_out, 0);
        check("fill_level16", fifo_level_out, 16);
      end
      if (i == 16) begin
        check("fill_17th_ready", rdy, 0);
        check("fill_17th_level", fifo_level_out, 16);
      end
    end

    enable_in = 1'b1;
    tick(40);
    check("run_pdm_clk_high", pdm_clk_out, 1);
    #3;
    rst_in = 1'b0;
    #1;
    check("arst_ready", audio_ready_out, 1);
    check("arst_pdm_clk", pdm_clk_out, 0);
    check("arst_pdm_out", pdm_out, 0);
    check("arst_underrun", underrun_out, 0);
    check("arst_level", fifo_level_out, 0);
    enable_in = 1'b0;
    #2;
    rst_in = 1'b1;

    for (int i = 0; i < 5; i++) if (tv[i].pre) push(tv[i].smp, rdy);
    check("prefill_level", fifo_level_out, 4);
    enable_in = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_period($sformatf("v%0d", i), -1, 1'b0, 8'h00, ones, pat, ur);
      check_period($sformatf("v%0d", i), ones, pat, tv[i].ones, tv[i].pat);
      check($sformatf("v%0d_underrun", i), ur, tv[i].ur);
      check($sformatf("v%0d_level", i), fifo_level_out, tv[i].lvl);
    end

    run_period("drain", -1, 1'b1, 8'h20, ones, pat, ur);
    check_period("drain", ones, pat, 64, 8'h11);
    check("wrap_push_underrun", ur, 1);
    check("wrap_push_level", fifo_level_out, 1);

    run_period("hold", 100, 1'b0, 8'h00, ones, pat, ur);
    check_period("hold", ones, pat, 64, 8'h11);
    check("hold_underrun", ur, 0);
    check("hold_level", fifo_level_out, 0);

    run_period("late", -1, 1'b0, 8'h00, ones, pat, ur);
    check_period("late", ones, pat, 160, 8'h5B);
    check("late_underrun", ur, 1);
    tick(2);
    check("underrun_pulses", n_under, 3);
    check("underrun_low", underrun_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pdm_audio_tx.md
# pdm_audio_tx

Playback-side PDM transmitter: accepts signed 8-bit audio samples at ~12 kHz over a valid/ready handshake, buffers them in a small FIFO, and converts them to a 1-bit pulse-density stream with a companion ~3.072 MHz bit clock. It is the output counterpart of the microphone PDM decimator, driving the audio amplifier/speaker pin from recorder playback data on the 98.3 MHz audio clock domain.

## Interface
- `PDM_COUNT_PERIOD`, 32: system clocks per PDM bit; even, ≥4.
- `NUM_PDM_SAMPLES`, 256: PDM bits per audio sample.
- `FIFO_DEPTH`, 16: sample buffer entries; power of two.
- `clk_in` input 1: audio clock (98.3 MHz).
- `rst_in` input 1: asynchronous, active-low reset.
- `enable_in` input 1: run modulator; low freezes timing and forces silence.
- `audio_in` input 8: signed two's-complement sample.
- `audio_valid_in` input 1: sample offered.
- `audio_ready_out` output 1: FIFO can accept; equals !full.
- `pdm_clk_out` output 1: bit clock, high for first half of each period.
- `pdm_out` output 1: PDM data bit.
- `underrun_out` output 1: single-cycle pulse, sample fetch found FIFO empty.
- `fifo_level_out` output $clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- Reset values: `audio_ready_out`=1, `pdm_clk_out`=0, `pdm_out`=0, `underrun_out`=0, `fifo_level_out`=0; all counters, accumulators, and current sample cleared to 0.
- Push on `audio_valid_in && audio_ready_out`. A push offered while full is dropped; the source holds it.
- Step counter 0..PDM_COUNT_PERIOD-1 while enabled. `pdm_clk_out` = (count < PDM_COUNT_PERIOD/2), registered. A bit step occurs when count == PDM_COUNT_PERIOD-1.
- Sample counter 0..NUM_PDM_SAMPLES-1 advances on each bit step. On the bit step where it wraps, pop the FIFO into the current sample. If the FIFO is empty, keep the previous sample and pulse `underrun_out`.
- First-order modulator: u = audio + 128, giving offset binary 0..255. The 9-bit sum is s = acc[7:0] + u. `pdm_out` takes s[8] and acc takes s, both on each bit step. Ones density is u/256.
- Push and pop in the same cycle:
  - Level is unchanged.
  - If the FIFO is empty at that moment, the pop underruns and the push lands.
- `enable_in` low:
  - Step and sample counters and the accumulator hold.
  - `pdm_clk_out`=0, `pdm_out`=0.
  - The FIFO still accepts pushes.
- Re-enable resumes from the held state.

## Timing
- `pdm_out` changes on the clock following the bit step, which coincides with the `pdm_clk_out` rising edge. The data is stable through the falling edge, where the receiver samples it.
- Popped sample affects the next bit step, i.e. PDM_COUNT_PERIOD cycles later.
- `audio_ready_out` is combinational from registered level: a push into the last free slot drops ready on the next cycle.
- `underrun_out` is asserted exactly one cycle, in the cycle after the failed pop.
- Reset asserted mid-stream clears everything immediately. The first bit step after release is at cycle PDM_COUNT_PERIOD-1.

## Configuration
- `PDM_SECOND_ORDER_EN` defined: second-order modulator replaces the first-order one.
  - Signed integrators i1 (12-bit) and i2 (16-bit), both saturating. x is the signed sample; fb = +128 if the previous out was 1, else -128.
  - i1 += x - fb; i2 += i1 - fb; out = (i2 ≥ 0).
  - Density tracks (x+128)/256 within ±2/256 over any 256-bit window after settling.
- Undefined: first-order accumulator only, with exact patterns as in Operation.

## Structure
- Package `pdm_pkg`:
  - Default constants PDM_COUNT_PERIOD=32 and NUM_PDM_SAMPLES=256, shared with the microphone decimator.
  - `typedef logic signed [7:0] audio_sample_t`.
- Sub-module `pdm_sample_fifo`: synchronous FIFO with push/pop/full/empty/level, instantiated once. The modulator and timing logic live in the top.

## Test plan
- After reset, push 0 then enable: after the first sample fetch, `pdm_out` alternates 0,1,0,1 on successive bit steps (first order); `pdm_clk_out` period is 32 clocks.
- Push -128: 256 consecutive zeros. Push 127: exactly 255 ones per 256 bits.
- Push 17 samples with no pops while enable is low: ready drops after the 16th push, 17th not accepted, level 16.
- Drain the FIFO: at the next sample wrap `underrun_out` pulses once, and the last sample keeps playing with its pattern unchanged.
- Push in the same cycle as a wrap with an empty FIFO: underrun pulses, level becomes 1, and the sample plays at the following wrap.
- Assert `rst_in` low mid-sample: all outputs return to reset values asynchronously. With `PDM_SECOND_ORDER_EN`, input 64 yields 192±2 ones per 256 bits.
